// File: rtl/pll_sup_pkg.sv
// Shared types, defaults and sizing helper for the rPLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAIL
    } pll_state_e;

    localparam int unsigned DEF_RST_PULSE_CYC    = 16;
    localparam int unsigned DEF_LOCK_TIMEOUT_CYC = 100000;
    localparam int unsigned DEF_LOCK_STABLE_CYC  = 1024;
    localparam int unsigned DEF_LOSS_FILTER_CYC  = 4;
    localparam int unsigned DEF_MAX_RETRY        = 3;

    localparam int unsigned RETRY_W = 4;
    localparam int unsigned LOSS_W  = 8;

    // Bits needed to count 0..max-1 over all per-state durations (at least 1).
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d);
        int unsigned m;
        int unsigned w;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        w = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < m) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync2.sv
// Two-flop synchronizer for a single asynchronous bit.
module pll_lock_supervisor_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], d};
        end
    end

    assign q = sync_q[1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences rPLL RESET, qualifies LOCK, and gates the downstream system reset.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
    parameter int unsigned LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
    parameter int unsigned LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
    parameter int unsigned LOSS_FILTER_CYC  = DEF_LOSS_FILTER_CYC,
    parameter int unsigned MAX_RETRY        = DEF_MAX_RETRY
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pll_lock_i,
    input  logic               relock_req_i,
    output logic               pll_reset_o,
    output logic               sys_reset_o,
    output logic               ready_o,
    output logic               fail_o,
    output logic [RETRY_W-1:0] retry_cnt_o,
    output logic [LOSS_W-1:0]  lock_loss_cnt_o
);

    localparam int unsigned CNT_W = cnt_width(RST_PULSE_CYC, LOCK_TIMEOUT_CYC,
                                              LOCK_STABLE_CYC, LOSS_FILTER_CYC);
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] LOSS_LAST    = CNT_W'(LOSS_FILTER_CYC - 1);

    pll_state_e         state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [RETRY_W-1:0] retry_n;
    logic [LOSS_W-1:0]  loss_n;
    logic               pll_reset_n, sys_reset_n, ready_n, fail_n;
    logic               lock_s;

    pll_lock_supervisor_sync2 u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pll_lock_i),
        .q     (lock_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= RESET_PLL;
            cnt             <= '0;
            pll_reset_o     <= 1'b1;
            sys_reset_o     <= 1'b1;
            ready_o         <= 1'b0;
            fail_o          <= 1'b0;
            retry_cnt_o     <= '0;
            lock_loss_cnt_o <= '0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            pll_reset_o     <= pll_reset_n;
            sys_reset_o     <= sys_reset_n;
            ready_o         <= ready_n;
            fail_o          <= fail_n;
            retry_cnt_o     <= retry_n;
            lock_loss_cnt_o <= loss_n;
        end
    end

    // Next-state, shared counter and next-output decode.
    always_comb begin
        state_n = state;
        cnt_n   = cnt + CNT_W'(1);
        retry_n = retry_cnt_o;
        loss_n  = lock_loss_cnt_o;

        case (state)
            RESET_PLL: begin
                if (cnt == RST_LAST) state_n = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_n = STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    if (retry_cnt_o == RETRY_W'(MAX_RETRY)) begin
                        state_n = FAIL;
                    end else begin
                        retry_n = retry_cnt_o + RETRY_W'(1);
                        state_n = RESET_PLL;
                    end
                end
            end
            STABLE: begin
                if (!lock_s) state_n = WAIT_LOCK;
                else if (cnt == STABLE_LAST) state_n = RUN;
            end
            RUN: begin
                if (lock_s) begin
                    cnt_n = '0;
                end else if (cnt == LOSS_LAST) begin
                    state_n = RESET_PLL;
                    if (lock_loss_cnt_o != '1) loss_n = lock_loss_cnt_o + LOSS_W'(1);
                end
                // A relock coinciding with a loss still keeps the loss counted above.
                if (relock_req_i) state_n = RESET_PLL;
            end
            FAIL: begin
                cnt_n = cnt;
                if (relock_req_i) begin
                    state_n = RESET_PLL;
                    retry_n = '0;
                end
            end
            default: begin
                state_n = RESET_PLL;
            end
        endcase

        if (state_n != state) cnt_n = '0;
        if (state_n == RUN) retry_n = '0;

        pll_reset_n = (state_n == RESET_PLL) || (state_n == FAIL);
        sys_reset_n = (state_n != RUN);
        ready_n     = (state_n == RUN);
        fail_n      = (state_n == FAIL);
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Randomized and scenario-driven checks of pll_lock_supervisor against a behavioural model.
module tb_pll_lock_supervisor;

    localparam int unsigned RST_PULSE_CYC    = 4;
    localparam int unsigned LOCK_TIMEOUT_CYC = 32;
    localparam int unsigned LOCK_STABLE_CYC  = 8;
    localparam int unsigned LOSS_FILTER_CYC  = 3;
    localparam int unsigned MAX_RETRY        = 2;

    localparam int M_PULSE = 0;
    localparam int M_WAIT  = 1;
    localparam int M_QUAL  = 2;
    localparam int M_RUN   = 3;
    localparam int M_DEAD  = 4;

    logic       clk;
    logic       reset;
    logic       pll_lock_i;
    logic       relock_req_i;
    logic       pll_reset_o;
    logic       sys_reset_o;
    logic       ready_o;
    logic       fail_o;
    logic [3:0] retry_cnt_o;
    logic [7:0] lock_loss_cnt_o;

    int checks;
    int errors;
    int edge_n;

    int m_phase;
    int m_elapsed;
    int m_low_run;
    int m_retries;
    int m_losses;
    bit m_sync0;
    bit m_sync1;

    pll_lock_supervisor #(
        .RST_PULSE_CYC    (RST_PULSE_CYC),
        .LOCK_TIMEOUT_CYC (LOCK_TIMEOUT_CYC),
        .LOCK_STABLE_CYC  (LOCK_STABLE_CYC),
        .LOSS_FILTER_CYC  (LOSS_FILTER_CYC),
        .MAX_RETRY        (MAX_RETRY)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pll_lock_i      (pll_lock_i),
        .relock_req_i    (relock_req_i),
        .pll_reset_o     (pll_reset_o),
        .sys_reset_o     (sys_reset_o),
        .ready_o         (ready_o),
        .fail_o          (fail_o),
        .retry_cnt_o     (retry_cnt_o),
        .lock_loss_cnt_o (lock_loss_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d at edge %0d", tag, got, want, edge_n);
        end
    endtask

    // Reference behaviour for one clock edge, using the inputs the DUT is about to sample.
    task automatic model_edge();
        bit ls;
        int nxt;
        ls      = m_sync1;
        m_sync1 = m_sync0;
        m_sync0 = pll_lock_i;
        if (reset) begin
            m_phase   = M_PULSE;
            m_elapsed = 0;
            m_low_run = 0;
            m_retries = 0;
            m_losses  = 0;
            m_sync0   = 1'b0;
            m_sync1   = 1'b0;
            return;
        end
        nxt = m_phase;
        m_elapsed++;
        case (m_phase)
            M_PULSE: if (m_elapsed == RST_PULSE_CYC) nxt = M_WAIT;
            M_WAIT: begin
                if (ls) nxt = M_QUAL;
                else if (m_elapsed == LOCK_TIMEOUT_CYC) begin
                    if (m_retries == MAX_RETRY) nxt = M_DEAD;
                    else begin
                        m_retries++;
                        nxt = M_PULSE;
                    end
                end
            end
            M_QUAL: begin
                if (!ls) nxt = M_WAIT;
                else if (m_elapsed == LOCK_STABLE_CYC) nxt = M_RUN;
            end
            M_RUN: begin
                m_low_run = ls ? 0 : m_low_run + 1;
                if (m_low_run == LOSS_FILTER_CYC) begin
                    m_losses = (m_losses < 255) ? m_losses + 1 : 255;
                    nxt = M_PULSE;
                end
                if (relock_req_i) begin
                    nxt = M_PULSE;
                    m_retries = 0;
                end
            end
            default: begin
                if (relock_req_i) begin
                    nxt = M_PULSE;
                    m_retries = 0;
                end
            end
        endcase
        if (nxt != m_phase) begin
            m_elapsed = 0;
            m_low_run = 0;
        end
        if (nxt == M_RUN) m_retries = 0;
        m_phase = nxt;
    endtask

    task automatic compare_all();
        check("pll_reset", 32'(pll_reset_o), 32'(m_phase == M_PULSE || m_phase == M_DEAD));
        check("sys_reset", 32'(sys_reset_o), 32'(m_phase != M_RUN));
        check("ready",     32'(ready_o),     32'(m_phase == M_RUN));
        check("fail",      32'(fail_o),      32'(m_phase == M_DEAD));
        check("retry_cnt", 32'(retry_cnt_o), 32'(m_retries));
        check("loss_cnt",  32'(lock_loss_cnt_o), 32'(m_losses));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        edge_n++;
        compare_all();
    endtask

    task automatic run_to(input int e);
        while (edge_n < e) step();
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        relock_req_i = 1'b0;
        step();
        step();
        reset  = 1'b0;
        edge_n = 0;
    endtask

    initial begin
        int hold;
        checks       = 0;
        errors       = 0;
        edge_n       = 0;
        reset        = 1'b1;
        pll_lock_i   = 1'b0;
        relock_req_i = 1'b0;
        m_phase      = M_PULSE;
        m_elapsed    = 0;
        m_low_run    = 0;
        m_retries    = 0;
        m_losses     = 0;
        m_sync0      = 1'b0;
        m_sync1      = 1'b0;

        // Clean lock: pulse, sync latency, stable window
        do_reset();
        check("rst_ready", 32'(ready_o), 0);
        check("rst_prst", 32'(pll_reset_o), 1);
        run_to(3);
        check("s1_prst_e3", 32'(pll_reset_o), 1);
        run_to(4);
        check("s1_prst_e4", 32'(pll_reset_o), 0);
        run_to(9);
        pll_lock_i = 1'b1;
        run_to(19);
        check("s1_ready_e19", 32'(ready_o), 0);
        run_to(20);
        check("s1_ready_e20", 32'(ready_o), 1);
        check("s1_sysrst_e20", 32'(sys_reset_o), 0);
        check("s1_retry_e20", 32'(retry_cnt_o), 0);

        // Glitch on the fifth stable cycle, then loss filtering in RUN
        pll_lock_i = 1'b0;
        do_reset();
        run_to(6);
        pll_lock_i = 1'b1;
        run_to(11);
        pll_lock_i = 1'b0;
        run_to(12);
        pll_lock_i = 1'b1;
        run_to(22);
        check("s2_ready_e22", 32'(ready_o), 0);
        run_to(23);
        check("s2_ready_e23", 32'(ready_o), 1);
        run_to(30);
        pll_lock_i = 1'b0;
        run_to(32);
        pll_lock_i = 1'b1;
        run_to(40);
        check("s4_short_dip_ready", 32'(ready_o), 1);
        check("s4_short_dip_loss", 32'(lock_loss_cnt_o), 0);
        pll_lock_i = 1'b0;
        run_to(43);
        pll_lock_i = 1'b1;
        run_to(44);
        check("s4_ready_e44", 32'(ready_o), 1);
        run_to(45);
        check("s4_ready_e45", 32'(ready_o), 0);
        check("s4_sysrst_e45", 32'(sys_reset_o), 1);
        check("s4_loss_e45", 32'(lock_loss_cnt_o), 1);
        run_to(48);
        check("s4_prst_e48", 32'(pll_reset_o), 1);
        run_to(49);
        check("s4_prst_e49", 32'(pll_reset_o), 0);
        run_to(58);
        check("s4_requal_ready", 32'(ready_o), 1);

        // No lock at all: three attempts then FAIL, then relock out of FAIL
        pll_lock_i = 1'b0;
        do_reset();
        run_to(36);
        check("s3_retry_e36", 32'(retry_cnt_o), 1);
        run_to(107);
        check("s3_fail_e107", 32'(fail_o), 0);
        run_to(108);
        check("s3_fail_e108", 32'(fail_o), 1);
        check("s3_retry_e108", 32'(retry_cnt_o), 2);
        check("s3_prst_e108", 32'(pll_reset_o), 1);
        check("s3_sysrst_e108", 32'(sys_reset_o), 1);
        run_to(115);
        pll_lock_i   = 1'b1;
        relock_req_i = 1'b1;
        step();
        relock_req_i = 1'b0;
        check("s5_fail_clr", 32'(fail_o), 0);
        check("s5_retry_clr", 32'(retry_cnt_o), 0);
        run_to(120);
        relock_req_i = 1'b1;
        step();
        relock_req_i = 1'b0;
        run_to(125);
        check("s5_ready_early", 32'(ready_o), 0);
        run_to(131);
        check("s5_ready", 32'(ready_o), 1);

        // Produce a loss, then reset while qualifying
        run_to(140);
        pll_lock_i = 1'b0;
        run_to(144);
        pll_lock_i = 1'b1;
        run_to(152);
        check("s6_loss_before", 32'(lock_loss_cnt_o), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("s6_prst", 32'(pll_reset_o), 1);
        check("s6_sysrst", 32'(sys_reset_o), 1);
        check("s6_ready", 32'(ready_o), 0);
        check("s6_loss", 32'(lock_loss_cnt_o), 0);
        check("s6_retry", 32'(retry_cnt_o), 0);

        // Random lock patterns with occasional relock and reset
        hold = 0;
        for (int i = 0; i < 5000; i++) begin
            if (hold == 0) begin
                pll_lock_i = ~pll_lock_i;
                if (pll_lock_i) hold = int'($urandom_range(1, 80));
                else if ($urandom_range(0, 5) == 0) hold = int'($urandom_range(30, 130));
                else hold = int'($urandom_range(1, 5));
            end
            hold--;
            relock_req_i = ($urandom_range(0, 149) == 0);
            reset        = ($urandom_range(0, 999) == 0);
            step();
        end
        reset        = 1'b0;
        relock_req_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
